// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: widths, divider
// state encoding and the sign helpers used around the unsigned divider core.
package hilo_muldiv_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int CNT_W      = $clog2(HILO_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Magnitude of an operand; unsigned operations pass the raw value through.
  function automatic logic [HILO_WIDTH-1:0] mag_of(
    input logic [HILO_WIDTH-1:0] value,
    input logic                  signed_op
  );
    mag_of = (signed_op && value[HILO_WIDTH-1]) ? -value : value;
  endfunction

  // Two's-complement negate when the latched sign says the result is negative.
  function automatic logic [HILO_WIDTH-1:0] apply_sign(
    input logic [HILO_WIDTH-1:0] value,
    input logic                  neg
  );
    apply_sign = neg ? -value : value;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Decode/operand bundle between the EX stage and the HI/LO unit, plus the
// unit's stall/busy and architectural HI/LO outputs.
interface hilo_muldiv_if
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
);

  logic             in_valid;
  logic             flush;
  logic             is_mult;
  logic             is_multu;
  logic             is_div;
  logic             is_divu;
  logic             hi_wen;
  logic             lo_wen;
  logic             hilo_read;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output in_valid, flush, is_mult, is_multu, is_div, is_divu,
           hi_wen, lo_wen, hilo_read, src_a, src_b,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  in_valid, flush, is_mult, is_multu, is_div, is_divu,
           hi_wen, lo_wen, hilo_read, src_a, src_b,
    output stall, busy, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_div_iter.sv
// Unsigned restoring radix-2 divider datapath: one quotient bit per step.
// The dividend is shifted out of the quotient register as quotient bits shift in.
module hilo_muldiv_div_iter
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;

  // Extra top bit of trial is the borrow: clear means the subtract fits.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: single-cycle multiply, MTHI/MTLO, and a 33-cycle
// iterative divide that stalls dependent HI/LO instructions while in flight.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  hilo_muldiv_if.slave  bus
);

  div_state_t       state;
  logic             busy_reg;
  logic [CNT_W-1:0] count;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic             any_hilo;
  logic             stall;
  logic             req;
  logic             div_op;
  logic             mul_op;
  logic             div_go;
  logic             mul_go;
  logic             hi_go;
  logic             lo_go;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  logic signed [2*WIDTH-1:0] mul_a;
  logic signed [2*WIDTH-1:0] mul_b;
  logic signed [2*WIDTH-1:0] mul_p;

  assign any_hilo = bus.is_mult | bus.is_multu | bus.is_div | bus.is_divu |
                    bus.hi_wen | bus.lo_wen | bus.hilo_read;

  // busy_reg is only ever set while the divider is out of IDLE, so no stall in IDLE.
  assign stall = busy_reg & bus.in_valid & any_hilo;
  assign req   = bus.in_valid & ~bus.flush & ~stall;

  assign div_op = bus.is_div | bus.is_divu;
  assign mul_op = bus.is_mult | bus.is_multu;

  assign div_go = req & div_op & (state == IDLE) & (bus.src_b != '0);
  assign mul_go = req & ~div_op & mul_op;
  assign hi_go  = req & ~div_op & ~mul_op & bus.hi_wen;
  assign lo_go  = req & ~div_op & ~mul_op & bus.lo_wen;

  // Divide by zero is still consumed by div_op above, it just never starts.
  assign a_mag = mag_of(bus.src_a, bus.is_div);
  assign b_mag = mag_of(bus.src_b, bus.is_div);

  // Extending to the full product width makes the truncated product exact
  // for both signed and unsigned operands.
  assign mul_a = {{WIDTH{bus.is_mult & bus.src_a[WIDTH-1]}}, bus.src_a};
  assign mul_b = {{WIDTH{bus.is_mult & bus.src_b[WIDTH-1]}}, bus.src_b};
  assign mul_p = mul_a * mul_b;

  hilo_muldiv_div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk       (clk),
    .load      (div_go),
    .step      (state == ITER),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_reg <= 1'b0;
      count    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (div_go) begin
            state    <= ITER;
            busy_reg <= 1'b1;
            count    <= CNT_W'(WIDTH - 1);
            q_neg    <= bus.is_div & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            r_neg    <= bus.is_div & bus.src_a[WIDTH-1];
          end
          if (mul_go) begin
            hi_reg <= mul_p[2*WIDTH-1:WIDTH];
            lo_reg <= mul_p[WIDTH-1:0];
          end
          if (hi_go) hi_reg <= bus.src_a;
          if (lo_go) lo_reg <= bus.src_a;
        end
        ITER: begin
          count <= count - 1'b1;
          if (count == '0) state <= FIX;
        end
        FIX: begin
          lo_reg   <= apply_sign(quotient, q_neg);
          hi_reg   <= apply_sign(remainder, r_neg);
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall = stall;
  assign bus.busy  = busy_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit. It consumes the per-instruction mult/div/mthi/mtlo/mfhi/mflo decode outputs and owns the architectural HI and LO registers.
- Multiply completes in a single cycle.
- Signed and unsigned divide run as an iterative restoring radix-2 state machine.
- The unit raises a stall to the pipeline while a divide is in flight and a dependent instruction tries to issue.

Parameters:
- WIDTH, 32, operand and HI/LO register width. Only 32 is supported; the counter width is derived from it.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  EX-stage instruction valid
- flush  in  1  exception/eret kill of the EX-stage instruction
- is_mult  in  1  MULT decoded
- is_multu  in  1  MULTU decoded
- is_div  in  1  DIV decoded
- is_divu  in  1  DIVU decoded
- hi_wen  in  1  MTHI decoded
- lo_wen  in  1  MTLO decoded
- hilo_read  in  1  MFHI or MFLO decoded
- src_a  in  WIDTH  rs data: dividend, multiplicand, or MTHI/MTLO source
- src_b  in  WIDTH  rt data: divisor or multiplier
- stall  out  1  hold the EX stage and all earlier stages
- busy  out  1  divide in progress
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Reset (synchronous, active-high):
  - hi = lo = 0, busy = 0, state IDLE, counter 0.
  - Reset mid-divide aborts it, with no HI/LO write.
  - stall = 0 in the cycle after reset.
- Request qualification:
  - req = in_valid & ~flush & ~stall.
  - Priority when several decode bits are asserted: div/divu > mult/multu > hi_wen/lo_wen.
- stall (combinational) = busy & in_valid & (any of is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen, hilo_read).
  - Unrelated instructions are never stalled.
  - stall is never asserted in IDLE.
- MULT/MULTU (no busy cycles):
  - On a req edge, {hi,lo} <= 64-bit product.
  - Operands are sign-extended for MULT and zero-extended for MULTU.
- MTHI/MTLO: on a req edge, hi <= src_a or lo <= src_a respectively; the other register is untouched.
- DIV/DIVU with src_b == 0:
  - Accepted, but HI/LO stay unchanged.
  - busy never rises and the state stays IDLE.
- DIV/DIVU with src_b != 0, state machine:
  - IDLE -> ITER on accept. Latch the operand magnitudes (absolute value for DIV, raw for DIVU), the quotient sign (a[31]^b[31], DIV only) and the remainder sign (a[31], DIV only). Counter <= WIDTH-1. busy <= 1.
  - ITER: each cycle performs one restoring step: shift the partial remainder left by 1, take the next dividend bit, trial-subtract the divisor, and set the quotient bit if the result is non-negative. Counter decrements; when the step runs with counter == 0, go to FIX.
  - FIX: negate the quotient and/or remainder per the latched signs, write lo <= quotient and hi <= remainder, busy <= 0, go to IDLE.
- Divide timing:
  - Accept at edge E; busy is high for edges E+1 through E+33 inclusive (32 ITER cycles plus 1 FIX cycle).
  - HI/LO update at the FIX edge.
  - A stalled dependent instruction is accepted the cycle after busy falls.
- Overflow case 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0, with no exception.
- busy is registered.
- flush only gates acceptance. A divide already in ITER/FIX always completes (its instruction has committed).
- No additional back-to-back hazard logic is required: the stall covers a divide followed by another HI/LO op.

Decomposition:
- Shared header: the state encodings IDLE/ITER/FIX as localparams, and the WIDTH-derived counter width. Place them beside the existing ALU op definitions header, as hilo.vh.
- One sub-module is natural: div_iter, the restoring-step datapath (partial remainder, quotient shift register, trial subtract). hilo_muldiv keeps the FSM, sign handling, multiply and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFF b=2 -> next edge hi=0xFFFFFFFF lo=0xFFFFFFFE, busy stays 0. MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE.
- DIVU a=100 b=7 -> busy high for exactly 33 cycles, then lo=0x0000000E hi=0x00000002. DIV a=7 b=0xFFFFFFFE -> lo=0xFFFFFFFD hi=0x00000001.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; DIVU a=5 b=0 -> hi/lo unchanged, busy never asserted.
- Divide accepted, then MFLO presented 5 cycles later -> stall=1 until busy falls. An ADDU presented during busy -> stall=0.
- MTHI 0x1234 with flush=1 -> hi unchanged. The same request with flush=0 -> hi=0x00001234, lo unchanged. DIV with flush=1 -> busy stays 0.
- reset asserted on the 10th ITER cycle -> next edge hi=lo=0, busy=0. A subsequent DIVU 9/3 -> lo=3 hi=0.
